bcd_2_bin_seq: RTL and testbench
================================

Name: bcd_2_bin_seq

Overview:
Iterative BCD-to-binary converter using reverse double-dabble: shift right, then subtract 3 from every digit that is 8 or more. It converts packed BCD values, such as scores or levels read back from storage or an entry UI, into binary for arithmetic and compare logic. It performs one shift per clock, with valid/ready handshakes on both the input and output sides. Its packing is bit-compatible with the existing combinational binary-to-BCD converter, so a value can round-trip through both blocks.

Parameters:
BIN_WIDTH, 8, width of the binary result and number of shift iterations.
BCD_WIDTH, 3, number of BCD digits at the input; digit 0 sits at bits [3:0].

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous, active-high reset
bcd_i  in  BCD_WIDTH*4  packed BCD operand
in_valid_i  in  1  bcd_i holds an operand
in_ready_o  out  1  block can accept an operand
bin_o  out  BIN_WIDTH  binary result, held stable while bin_valid_o=1
ovf_o  out  1  result did not fit in BIN_WIDTH bits
bin_valid_o  out  1  result available
bin_ready_i  in  1  consumer accepts the result

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset values:
  - State is IDLE, in_ready_o=1 and bin_valid_o=0.
  - bin_o=0 and ovf_o=0.
  - Iteration counter and shift register are 0.
- Internal shift register: sr = {bcd_part[BCD_WIDTH*4-1:0], bin_part[BIN_WIDTH-1:0]}.
- State IDLE:
  - in_ready_o=1.
  - On in_valid_i && in_ready_o: load bcd_part=bcd_i, bin_part=0 and cnt=0, then go to SHIFT.
- State SHIFT:
  - in_ready_o=0.
  - Each cycle: shift sr right by 1, so bcd_part[0] enters bin_part MSB.
  - Then, for each digit of the shifted bcd_part: if the digit is 8 or more, subtract 3 (4-bit, no borrow across digits).
  - cnt increments. When cnt reaches BIN_WIDTH-1 in this cycle, go to DONE.
  - This gives exactly BIN_WIDTH iterations.
- State DONE:
  - bin_valid_o=1, bin_o=bin_part, ovf_o=(bcd_part!=0).
  - Outputs are held while bin_ready_i=0.
  - On bin_ready_i=1: go to IDLE with bin_valid_o=0 at the next edge.
  - There is no same-cycle accept of a new operand; throughput is 1 result per BIN_WIDTH+2 cycles.
- Latency: acceptance at edge k gives bin_valid_o=1 after edge k+BIN_WIDTH.
- Overflow: bin_o equals the decimal value mod 2^BIN_WIDTH; ovf_o=1 if the value is 2^BIN_WIDTH or more.
- Illegal digits (A-F) without the check feature: conversion still runs, and the result is whatever the algorithm produces. Behaviour is deterministic but not specified numerically.
- rst_i mid-SHIFT or mid-DONE: abort immediately to reset values; the result is lost.
- in_valid_i while busy: ignored (in_ready_o=0). The producer must hold its data.
- bin_o and ovf_o keep the last result after DONE exits. bin_valid_o is the only qualifier.

Optional Feature:
- Macro: BCD_2_BIN_DIGIT_CHECK_EN.
- When defined:
  - Adds output port err_o (1 bit, reset 0).
  - At load, any digit of bcd_i greater than 9 is flagged and the flag is registered.
  - err_o is valid with bin_valid_o, and in DONE it is held alongside bin_o.
  - The conversion still runs for full latency; timing is identical.
- When undefined:
  - The err_o port and its checking logic do not exist.
  - Illegal digits behave as described under Behaviour.

Decomposition:
- Package bcd_pkg holds:
  - The state enum {IDLE, SHIFT, DONE}.
  - Constant BCD_DIGIT_W=4.
  - Constants BCD_CORR_THR=4'd8 and BCD_CORR_VAL=4'd3.
  - Function bcd_digit_illegal(digit).
- One sub-module, bcd_digit_corr: a combinational per-digit "if digit is 8 or more, subtract 3" unit.
  - It is instantiated BCD_WIDTH times via generate.
  - It mirrors the add-3 cell of the forward direction.

Test Plan:
1. Reset, then bcd_i=12'h255 with in_valid_i=1 -> bin_valid_o after 8 cycles, bin_o=8'd255, ovf_o=0.
2. bcd_i=12'h000 -> bin_o=0, ovf_o=0; bcd_i=12'h001 -> bin_o=1.
3. bcd_i=12'h256 -> bin_o=8'd0, ovf_o=1; bcd_i=12'h999 -> bin_o=8'd231 (999 mod 256), ovf_o=1.
4. Backpressure: hold bin_ready_i=0 for 5 cycles in DONE, and drive in_valid_i=1 with a new operand. Required response: bin_o stays stable, in_ready_o=0, and the new operand is accepted only after DONE has exited and the block is back in IDLE.
5. Assert rst_i at iteration 3 of bcd_i=12'h128 -> next cycle in IDLE with bin_valid_o=0. A following 12'h128 converts to 8'd128.
6. With BCD_2_BIN_DIGIT_CHECK_EN defined, bcd_i=12'h1A3 -> err_o=1 alongside bin_valid_o, with the same latency. bcd_i=12'h193 -> err_o=0, bin_o=8'd193.
- Random round-trip: feed through the forward converter, then this block, for all 0..255 -> identity.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
// Also holds the illegal-digit helper used when BCD_2_BIN_DIGIT_CHECK_EN is defined.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    localparam int         BCD_DIGIT_W  = 4;
    localparam logic [3:0] BCD_CORR_THR = 4'd8;
    localparam logic [3:0] BCD_CORR_VAL = 4'd3;

    function automatic logic bcd_digit_illegal(input logic [BCD_DIGIT_W-1:0] digit);
        return digit > 4'd9;
    endfunction

endpackage

// File: rtl/bcd_digit_corr.sv
// Per-digit correction cell for reverse double-dabble: digits of 8 or more lose 3.
// Inverse of the add-3 cell in the forward binary-to-BCD converter.
module bcd_digit_corr
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] corr
);

    assign corr = (digit >= BCD_CORR_THR) ? (digit - BCD_CORR_VAL) : digit;

endmodule

// File: rtl/bcd_2_bin_seq.sv
// Iterative BCD-to-binary converter, one reverse double-dabble shift per clock.
// Define BCD_2_BIN_DIGIT_CHECK_EN to add err_o, flagging operands with digits above 9.
//
// state | meaning
// IDLE  | ready for an operand; in_ready_o=1
// SHIFT | BIN_WIDTH shift/correct iterations
// DONE  | result presented on bin_o until bin_ready_i
module bcd_2_bin_seq
    import bcd_pkg::*;
#(
    parameter int BIN_WIDTH = 8,
    parameter int BCD_WIDTH = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [BCD_WIDTH*4-1:0] bcd_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    output logic [BIN_WIDTH-1:0]   bin_o,
    output logic                   ovf_o,
`ifdef BCD_2_BIN_DIGIT_CHECK_EN
    output logic                   err_o,
`endif
    output logic                   bin_valid_o,
    input  logic                   bin_ready_i
);

    localparam int BCD_BITS = BCD_WIDTH * BCD_DIGIT_W;
    localparam int SR_W     = BCD_BITS + BIN_WIDTH;
    localparam int CNT_W    = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;

    bcd_state_t           state_q, state_d;
    logic [SR_W-1:0]      sr_q, sr_d, sr_shift;
    logic [BCD_BITS-1:0]  bcd_corr;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIN_WIDTH-1:0] bin_q;
    logic                 ovf_q;
    logic                 load_res;
    logic                 last_iter;
    logic                 accept;

    assign sr_shift  = sr_q >> 1;
    assign last_iter = (cnt_q == CNT_W'(BIN_WIDTH - 1));
    assign accept    = (state_q == IDLE) && in_valid_i;

    for (genvar g = 0; g < BCD_WIDTH; g++) begin : g_corr
        bcd_digit_corr u_corr (
            .digit (sr_shift[BIN_WIDTH + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .corr  (bcd_corr[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        load_res = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    sr_d    = {bcd_i, BIN_WIDTH'(0)};
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sr_d  = {bcd_corr, sr_shift[BIN_WIDTH-1:0]};
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    load_res = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (bin_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Result is captured into its own register so it survives the next load of sr.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            if (load_res) begin
                bin_q <= sr_d[BIN_WIDTH-1:0];
                ovf_q <= |bcd_corr;
            end
        end
    end

`ifdef BCD_2_BIN_DIGIT_CHECK_EN
    logic err_in;
    logic err_q;

    always_comb begin
        err_in = 1'b0;
        for (int i = 0; i < BCD_WIDTH; i++) begin
            err_in = err_in | bcd_digit_illegal(bcd_i[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= err_in;
        end
    end

    assign err_o = err_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

    assign in_ready_o  = (state_q == IDLE);
    assign bin_valid_o = (state_q == DONE);
    assign bin_o       = bin_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_bcd_2_bin_seq.sv
// Self-checking bench for bcd_2_bin_seq: directed cases, random decimals and a full round-trip.
// Expected values come from plain decimal arithmetic on the operand.
module tb_bcd_2_bin_seq;

    localparam int BIN_WIDTH = 8;
    localparam int BCD_WIDTH = 3;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic [BCD_WIDTH*4-1:0] bcd_i;
    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [BIN_WIDTH-1:0]   bin_o;
    logic                   ovf_o;
    logic                   bin_valid_o;
    logic                   bin_ready_i;
`ifdef BCD_2_BIN_DIGIT_CHECK_EN
    logic                   err_o;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    bcd_2_bin_seq #(.BIN_WIDTH(BIN_WIDTH), .BCD_WIDTH(BCD_WIDTH)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .bcd_i       (bcd_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .bin_o       (bin_o),
        .ovf_o       (ovf_o),
`ifdef BCD_2_BIN_DIGIT_CHECK_EN
        .err_o       (err_o),
`endif
        .bin_valid_o (bin_valid_o),
        .bin_ready_i (bin_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Forward converter reference: decimal value to packed BCD.
    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int bcd_value(input logic [11:0] b);
        return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    // Called at the negedge right after the acceptance edge; leaves the block in DONE.
    task automatic wait_result(input string tag, output int lat);
        lat = 0;
        while (!bin_valid_o && lat < 40) begin
            @(negedge clk_i);
            lat++;
        end
        chk({tag, " latency"}, lat, BIN_WIDTH);
    endtask

    task automatic release_result(input string tag);
        bin_ready_i = 1'b1;
        @(negedge clk_i);
        bin_ready_i = 1'b0;
        chk({tag, " valid drop"}, bin_valid_o, 0);
        chk({tag, " ready back"}, in_ready_o, 1);
    endtask

    task automatic accept_op(input string tag, input logic [11:0] b);
        chk({tag, " in_ready"}, in_ready_o, 1);
        bcd_i      = b;
        in_valid_i = 1'b1;
        @(negedge clk_i);
        in_valid_i = 1'b0;
        bcd_i      = $urandom;
    endtask

    task automatic convert(input string tag, input logic [11:0] b, input bit check_val);
        int lat;
        int v;
        v = bcd_value(b);
        accept_op(tag, b);
        wait_result(tag, lat);
        if (check_val) begin
            chk({tag, " bin"}, bin_o, v % 256);
            chk({tag, " ovf"}, ovf_o, (v >= 256) ? 1 : 0);
        end
        release_result(tag);
    endtask

    initial begin
        int lat;
        logic [BIN_WIDTH-1:0] held;
        int order [256];

        rst_i       = 1'b1;
        bcd_i       = '0;
        in_valid_i  = 1'b0;
        bin_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("rst in_ready", in_ready_o, 1);
        chk("rst valid", bin_valid_o, 0);
        chk("rst bin", bin_o, 0);
        chk("rst ovf", ovf_o, 0);
`ifdef BCD_2_BIN_DIGIT_CHECK_EN
        chk("rst err", err_o, 0);
`endif
        rst_i = 1'b0;
        @(negedge clk_i);

        convert("t255", 12'h255, 1);
        convert("t000", 12'h000, 1);
        convert("t001", 12'h001, 1);
        convert("t256", 12'h256, 1);
        convert("t999", 12'h999, 1);

        // Backpressure: result held while a new operand waits.
        accept_op("bp", 12'h321);
        wait_result("bp", lat);
        held = bin_o;
        chk("bp bin", held, 321 % 256);
        bcd_i      = 12'h042;
        in_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("bp hold bin", bin_o, held);
            chk("bp hold valid", bin_valid_o, 1);
            chk("bp busy", in_ready_o, 0);
        end
        bin_ready_i = 1'b1;
        @(negedge clk_i);
        bin_ready_i = 1'b0;
        chk("bp idle", in_ready_o, 1);
        chk("bp valid drop", bin_valid_o, 0);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        chk("bp accepted", in_ready_o, 0);
        wait_result("bp2", lat);
        chk("bp2 bin", bin_o, 42);
        release_result("bp2");

        // Reset in the middle of a conversion.
        accept_op("rst_mid", 12'h128);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("rst_mid valid", bin_valid_o, 0);
        chk("rst_mid ready", in_ready_o, 1);
        chk("rst_mid bin", bin_o, 0);
        convert("t128", 12'h128, 1);

`ifdef BCD_2_BIN_DIGIT_CHECK_EN
        accept_op("err1", 12'h1A3);
        wait_result("err1", lat);
        chk("err1 err", err_o, 1);
        release_result("err1");
        accept_op("err0", 12'h193);
        wait_result("err0", lat);
        chk("err0 err", err_o, 0);
        chk("err0 bin", bin_o, 193);
        release_result("err0");
`else
        convert("illegal", 12'h1A3, 0);
        convert("t193", 12'h193, 1);
`endif

        for (int i = 0; i < 40; i++) begin
            convert("rand", to_bcd(int'($urandom_range(0, 999))), 1);
        end

        // Round-trip every byte value in shuffled order.
        for (int i = 0; i < 256; i++) order[i] = i;
        for (int i = 255; i > 0; i--) begin
            int j;
            int t;
            j = int'($urandom_range(0, i));
            t = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        for (int i = 0; i < 256; i++) begin
            accept_op("rt", to_bcd(order[i]));
            wait_result("rt", lat);
            chk("rt bin", bin_o, order[i]);
            chk("rt ovf", ovf_o, 0);
            bin_ready_i = 1'b1;
            @(negedge clk_i);
            bin_ready_i = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
